// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined RISC-V core: datapath widths, control-bundle bit map, register indices.
package riscv_pkg;
    localparam int XLEN         = 32;
    localparam int CTRL_W       = 12;
    localparam int REG_W        = 5;
    localparam int BUBBLE_CNT_W = 16;

    localparam int REGWRITE_BIT = 0;
    localparam int ALUSRC_BIT   = 1;
    localparam int MEMWRITE_BIT = 2;
    localparam int MEMREAD_BIT  = 3;
    localparam int MEMTOREG_BIT = 4;
    localparam int BRANCH_BIT   = 5;
    localparam int JUMP_BIT     = 6;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // True when a write to 'wr' is visible to a read of 'rs' (x0 never matches).
    function automatic logic reg_hit(input logic [REG_W-1:0] wr, input logic [REG_W-1:0] rs);
        return (wr != ZERO_REG) && (wr == rs);
    endfunction
endpackage

// File: rtl/wb_bypass_mux.sv
// Per-port operand select: register-file data, or same-cycle writeback data when WB_BYPASS_EN is defined.
// Combinational, no backpressure; reads of x0 always return zero.
module wb_bypass_mux
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_rdata,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic [XLEN-1:0]  op
);
`ifdef WB_BYPASS_EN
    // The register file writes on the edge but reads the old value, so forward the pending write.
    always_comb begin
        op = rf_rdata;
        if (rs == ZERO_REG)
            op = '0;
        else if (wb_regwrite && reg_hit(wb_rd, rs))
            op = wb_wdata;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_wdata};

    always_comb begin
        op = rf_rdata;
        if (rs == ZERO_REG)
            op = '0;
    end
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and bubble counter; WB_BYPASS_EN enables the WB bypass.
// Latency 1 cycle; ex_stall holds all state and raises id_stall, flush squashes the ID instruction.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int CNT_W = BUBBLE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;
    logic            load_use;
    logic            clear_fields;
    logic            count_bubble;

    wb_bypass_mux u_mux1 (
        .rs          (id_rs1),
        .rf_rdata    (rf_rdata1),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_wdata    (wb_wdata),
        .op          (op1_sel)
    );

    wb_bypass_mux u_mux2 (
        .rs          (id_rs2),
        .rf_rdata    (rf_rdata2),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_wdata    (wb_wdata),
        .op          (op2_sel)
    );

    assign load_use = ex_valid && ex_ctrl[MEMREAD_BIT] && (ex_rd != ZERO_REG) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign id_stall     = ex_stall || (load_use && !flush);
    // Flush outranks stall; a bubble only happens when neither flush nor stall is present.
    assign clear_fields = flush || (!ex_stall && load_use);
    assign count_bubble = !flush && !ex_stall && load_use && (bubble_cnt != {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_imm     <= '0;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
            bubble_cnt <= '0;
        end else begin
            if (clear_fields) begin
                ex_valid <= 1'b0;
                ex_pc    <= '0;
                ex_imm   <= '0;
                ex_op1   <= '0;
                ex_op2   <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
                ex_rd    <= '0;
                ex_ctrl  <= '0;
            end else if (!ex_stall) begin
                ex_valid <= id_valid;
                ex_pc    <= id_pc;
                ex_imm   <= id_imm;
                ex_op1   <= op1_sel;
                ex_op2   <= op2_sel;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_rd    <= id_rd;
                ex_ctrl  <= id_valid ? id_ctrl : '0;
            end
            if (count_bubble)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against a behavioural pipeline-register model.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int SAT_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, rf_rdata1, rf_rdata2, wb_wdata;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [11:0] id_ctrl;
    logic        wb_regwrite, ex_stall, flush;

    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;
    logic [15:0] bubble_cnt;

    logic        sat_id_stall, sat_ex_valid;
    logic [31:0] sat_ex_pc, sat_ex_imm, sat_ex_op1, sat_ex_op2;
    logic [4:0]  sat_ex_rs1, sat_ex_rs2, sat_ex_rd;
    logic [11:0] sat_ex_ctrl;
    logic [SAT_W-1:0] sat_bubble_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model of the EX-side state
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_op1, m_op2;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [11:0] m_ctrl;
    logic [15:0] m_cnt;
    logic [SAT_W-1:0] m_cnt_sat;

    id_ex_stage u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ex_stall(ex_stall), .flush(flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    id_ex_stage #(.CNT_W(SAT_W)) u_dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ex_stall(ex_stall), .flush(flush),
        .id_stall(sat_id_stall), .ex_valid(sat_ex_valid), .ex_pc(sat_ex_pc), .ex_imm(sat_ex_imm),
        .ex_op1(sat_ex_op1), .ex_op2(sat_ex_op2), .ex_rs1(sat_ex_rs1), .ex_rs2(sat_ex_rs2),
        .ex_rd(sat_ex_rd), .ex_ctrl(sat_ex_ctrl), .bubble_cnt(sat_bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rdata);
        if (rs == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_regwrite && wb_rd == rs) return wb_wdata;
`endif
        return rdata;
    endfunction

    function automatic logic ref_load_use();
        return m_valid && m_ctrl[MEMREAD_BIT] && (m_rd != 5'd0) && id_valid &&
               ((m_rd == id_rs1) || (m_rd == id_rs2));
    endfunction

    function automatic logic ref_stall();
        return ex_stall || (ref_load_use() && !flush);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_cnt = 0;
        m_cnt_sat = 0;
    endtask

    task automatic model_step();
        logic lu;
        lu = ref_load_use();
        if (flush) begin
            model_clear();
        end else if (!ex_stall) begin
            if (lu) begin
                model_clear();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_cnt_sat != {SAT_W{1'b1}}) m_cnt_sat = m_cnt_sat + 1'b1;
            end else begin
                m_valid = id_valid;
                m_pc    = id_pc;
                m_imm   = id_imm;
                m_op1   = ref_operand(id_rs1, rf_rdata1);
                m_op2   = ref_operand(id_rs2, rf_rdata2);
                m_rs1   = id_rs1;
                m_rs2   = id_rs2;
                m_rd    = id_rd;
                m_ctrl  = id_valid ? id_ctrl : 12'd0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_imm = 0; id_ctrl = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; wb_regwrite = 0; wb_rd = 0; wb_wdata = 0;
        ex_stall = 0; flush = 0;
    endtask

    task automatic drive_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                               input logic [11:0] ctrl, input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm;
        id_ctrl = ctrl; rf_rdata1 = d1; rf_rdata2 = d2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_assert++; if ({ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_ctrl, bubble_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got valid=%0h pc=%h ctrl=%h cnt=%0d, want all 0", ex_valid, ex_pc, ex_ctrl, bubble_cnt); end
        n_assert++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_id_stall: got %0b want 0", id_stall); end
        #5 rst = 1'b1;
        tick();
        // Build up live state, then reset mid-cycle
        drive_instr(1, 32'h40, 1, 2, 6, 32'h8, 12'h019, 32'h11, 32'h22);
        tick();
        drive_instr(1, 32'h44, 6, 3, 4, 32'h0, 12'h001, 32'h33, 32'h44);
        tick();
        n_assert++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL reset_pre_cnt: got %0d want 1", bubble_cnt); end
        tick();
        n_assert++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: got %0b want 1", ex_valid); end
        drive_idle();
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_assert++; if ({ex_valid, ex_pc, ex_op1, ex_op2, ex_rd, ex_ctrl} !== '0) begin
            n_fail++; $display("FAIL reset_async_fields: got valid=%0b pc=%h op1=%h ctrl=%h, want 0", ex_valid, ex_pc, ex_op1, ex_ctrl); end
        n_assert++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_async_cnt: got %0d want 0", bubble_cnt); end
        n_assert++; if (sat_bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_async_sat_cnt: got %0d want 0", sat_bubble_cnt); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_capture();
        drive_instr(1, 32'h100, 5, 6, 9, 32'h10, 12'h003, 32'hA, 32'hB);
        tick();
        n_assert++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL capture_pc: got %h want 00000100", ex_pc); end
        n_assert++; if (ex_op1 !== 32'hA) begin n_fail++; $display("FAIL capture_op1: got %h want 0000000a", ex_op1); end
        n_assert++; if (ex_op2 !== 32'hB) begin n_fail++; $display("FAIL capture_op2: got %h want 0000000b", ex_op2); end
        n_assert++; if (ex_imm !== 32'h10) begin n_fail++; $display("FAIL capture_imm: got %h want 00000010", ex_imm); end
        n_assert++; if ({ex_valid, ex_ctrl, ex_rs1, ex_rd} !== {1'b1, 12'h003, 5'd5, 5'd9}) begin
            n_fail++; $display("FAIL capture_ctl: got v=%0b ctrl=%h rs1=%0d rd=%0d want v=1 ctrl=003 rs1=5 rd=9", ex_valid, ex_ctrl, ex_rs1, ex_rd); end
        drive_instr(0, 32'h104, 1, 2, 3, 32'h4, 12'hFFF, 32'h1, 32'h2);
        tick();
        n_assert++; if ({ex_valid, ex_ctrl} !== 13'd0) begin
            n_fail++; $display("FAIL capture_invalid: got v=%0b ctrl=%h want v=0 ctrl=000", ex_valid, ex_ctrl); end
    endtask

    task automatic test_load_use();
        drive_instr(1, 32'h200, 1, 2, 7, 32'h0, 12'h019, 32'h5, 32'h6);
        tick();
        drive_instr(1, 32'h204, 1, 7, 8, 32'h4, 12'h001, 32'h21, 32'h22);
        #1;
        n_assert++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", id_stall); end
        tick();
        n_assert++; if ({ex_valid, ex_ctrl, ex_op2} !== 45'd0) begin
            n_fail++; $display("FAIL lu_bubble: got v=%0b ctrl=%h op2=%h want zeros", ex_valid, ex_ctrl, ex_op2); end
        n_assert++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", bubble_cnt); end
        n_assert++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release: got %0b want 0", id_stall); end
        tick();
        n_assert++; if ({ex_valid, ex_pc, ex_op2} !== {1'b1, 32'h204, 32'h22}) begin
            n_fail++; $display("FAIL lu_capture: got v=%0b pc=%h op2=%h want v=1 pc=00000204 op2=00000022", ex_valid, ex_pc, ex_op2); end
        drive_instr(1, 32'h208, 2, 3, 0, 32'h0, 12'h019, 32'h1, 32'h2);
        tick();
        drive_instr(1, 32'h20C, 0, 0, 9, 32'h0, 12'h001, 32'h1, 32'h2);
        #1;
        n_assert++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_rd_zero: got %0b want 0", id_stall); end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] want1, want2;
        drive_instr(1, 32'h300, 3, 4, 10, 32'h0, 12'h001, 32'h1, 32'h44);
        wb_regwrite = 1; wb_rd = 3; wb_wdata = 32'hDEAD;
        tick();
`ifdef WB_BYPASS_EN
        want1 = 32'hDEAD;
`else
        want1 = 32'h1;
`endif
        n_assert++; if (ex_op1 !== want1) begin n_fail++; $display("FAIL bypass_op1: got %h want %h", ex_op1, want1); end
        n_assert++; if (ex_op2 !== 32'h44) begin n_fail++; $display("FAIL bypass_op2_nohit: got %h want 00000044", ex_op2); end
        wb_rd = 4; wb_wdata = 32'hBEEF;
        tick();
`ifdef WB_BYPASS_EN
        want2 = 32'hBEEF;
`else
        want2 = 32'h44;
`endif
        n_assert++; if ({ex_op1, ex_op2} !== {32'h1, want2}) begin
            n_fail++; $display("FAIL bypass_port2: got op1=%h op2=%h want op1=00000001 op2=%h", ex_op1, ex_op2, want2); end
        wb_rd = 0; wb_wdata = 32'hDEAD;
        tick();
        n_assert++; if (ex_op1 !== 32'h1) begin n_fail++; $display("FAIL bypass_wbrd0: got %h want 00000001", ex_op1); end
        id_rs1 = 0; rf_rdata1 = 32'h77;
        tick();
        n_assert++; if (ex_op1 !== 32'h0) begin n_fail++; $display("FAIL bypass_x0: got %h want 00000000", ex_op1); end
        wb_regwrite = 0;
    endtask

    task automatic test_priority();
        logic [15:0] base;
        base = m_cnt;
        drive_instr(1, 32'h400, 1, 2, 7, 32'h0, 12'h019, 32'h1, 32'h2);
        tick();
        drive_instr(1, 32'h404, 7, 2, 8, 32'h0, 12'h001, 32'h3, 32'h4);
        flush = 1; ex_stall = 1;
        #1;
        n_assert++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL prio_fs_stall: got %0b want 1", id_stall); end
        tick();
        n_assert++; if ({ex_valid, ex_ctrl, bubble_cnt} !== {13'd0, base}) begin
            n_fail++; $display("FAIL prio_flush_stall: got v=%0b ctrl=%h cnt=%0d want v=0 ctrl=000 cnt=%0d", ex_valid, ex_ctrl, bubble_cnt, base); end
        flush = 0; ex_stall = 0;
        drive_instr(1, 32'h400, 1, 2, 7, 32'h0, 12'h019, 32'h1, 32'h2);
        tick();
        drive_instr(1, 32'h404, 7, 2, 8, 32'h0, 12'h001, 32'h3, 32'h4);
        flush = 1;
        #1;
        n_assert++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL prio_flush_lu_stall: got %0b want 0", id_stall); end
        tick();
        n_assert++; if ({ex_valid, bubble_cnt} !== {1'b0, base}) begin
            n_fail++; $display("FAIL prio_flush_lu: got v=%0b cnt=%0d want v=0 cnt=%0d", ex_valid, bubble_cnt, base); end
        flush = 0;
        drive_instr(1, 32'h400, 1, 2, 7, 32'h0, 12'h019, 32'h1, 32'h2);
        tick();
        drive_instr(1, 32'h404, 7, 2, 8, 32'h0, 12'h001, 32'h3, 32'h4);
        ex_stall = 1;
        tick();
        tick();
        n_assert++; if ({ex_valid, ex_rd, ex_ctrl, ex_pc, bubble_cnt} !== {1'b1, 5'd7, 12'h019, 32'h400, base}) begin
            n_fail++; $display("FAIL prio_stall_lu: got v=%0b rd=%0d ctrl=%h pc=%h cnt=%0d want v=1 rd=7 ctrl=019 pc=00000400 cnt=%0d", ex_valid, ex_rd, ex_ctrl, ex_pc, bubble_cnt, base); end
        ex_stall = 0;
        tick();
        n_assert++; if ({ex_valid, bubble_cnt} !== {1'b0, base + 16'd1}) begin
            n_fail++; $display("FAIL prio_lu_after_stall: got v=%0b cnt=%0d want v=0 cnt=%0d", ex_valid, bubble_cnt, base + 16'd1); end
        drive_instr(1, 32'h500, 9, 10, 11, 32'h50, 12'h003, 32'h5A5A, 32'hA5A5);
        tick();
        ex_stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(1, $urandom, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd1, $urandom, 12'h001, $urandom, $urandom);
            tick();
            n_assert++; if ({ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd} !== {1'b1, 32'h500, 32'h5A5A, 32'hA5A5, 32'h50, 5'd11}) begin
                n_fail++; $display("FAIL prio_hold_%0d: got v=%0b pc=%h op1=%h op2=%h imm=%h rd=%0d", i, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd); end
        end
        ex_stall = 0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 70; i++) begin
            drive_instr(1, 32'h600, 1, 2, 5, 32'h0, 12'h008, 32'h1, 32'h2);
            tick();
            drive_instr(1, 32'h604, 5, 2, 6, 32'h0, 12'h001, 32'h1, 32'h2);
            tick();
            n_assert++; if (sat_bubble_cnt !== m_cnt_sat) begin
                n_fail++; $display("FAIL sat_step_%0d: got %0d want %0d", i, sat_bubble_cnt, m_cnt_sat); end
        end
        n_assert++; if (sat_bubble_cnt !== {SAT_W{1'b1}}) begin
            n_fail++; $display("FAIL sat_sticky: got %0d want %0d", sat_bubble_cnt, {SAT_W{1'b1}}); end
        n_assert++; if (bubble_cnt !== m_cnt) begin
            n_fail++; $display("FAIL sat_wide_cnt: got %0d want %0d", bubble_cnt, m_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive_instr(5'($urandom_range(0, 3)) != 0, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), $urandom, 12'($urandom), $urandom, $urandom);
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 3));
            wb_wdata    = $urandom;
            flush       = ($urandom_range(0, 9) == 0);
            ex_stall    = ($urandom_range(0, 6) == 0);
            #1;
            n_assert++; if (id_stall !== ref_stall()) begin
                n_fail++; $display("FAIL rand_stall_%0d: got %0b want %0b", c, id_stall, ref_stall()); end
            tick();
            n_assert++; if ({ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_ctrl} !==
                            {m_valid, m_pc, m_imm, m_op1, m_op2, m_rs1, m_rs2, m_rd, m_ctrl}) begin
                n_fail++; $display("FAIL rand_ex_%0d: got %h want %h", c,
                    {ex_valid, ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_ctrl},
                    {m_valid, m_pc, m_imm, m_op1, m_op2, m_rs1, m_rs2, m_rd, m_ctrl}); end
            n_assert++; if ({bubble_cnt, sat_bubble_cnt} !== {m_cnt, m_cnt_sat}) begin
                n_fail++; $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d", c, bubble_cnt, sat_bubble_cnt, m_cnt, m_cnt_sat); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_bypass();
        test_priority();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
